lpr_cmd_sequencer: RTL and testbench

//  Consumes the 32-bit HPS command word driven by the command PIO.

---
 rtl/lpr_cmd_pkg.sv | 30 +++
 rtl/lpr_cmd_sequencer_if.sv | 23 ++
 rtl/lpr_cmd_field_decode.sv | 15 +
 rtl/lpr_cmd_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_lpr_cmd_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lpr_cmd_pkg.sv
// Shared definitions for the LPR command sequencer: command fields, opcodes,
// status error codes and FSM state encoding.
package lpr_cmd_pkg;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int TAG_MSB = 27;
    localparam int TAG_LSB = 24;
    localparam int ARG_MSB = 23;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_START = 4'd1;
    localparam logic [3:0] OP_ABORT = 4'd2;
    localparam logic [3:0] OP_SRST  = 4'd3;
    localparam logic [3:0] OP_CLR   = 4'd4;

    localparam logic [7:0] ERR_NONE    = 8'h00;
    localparam logic [7:0] ERR_ILLEGAL = 8'h01;
    localparam logic [7:0] ERR_BUSY    = 8'h02;
    localparam logic [7:0] ERR_TIMEOUT = 8'h03;
    localparam logic [7:0] ERR_ENGINE  = 8'h04;
    localparam logic [7:0] ERR_ABORTED = 8'h05;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DISPATCH  = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/lpr_cmd_sequencer_if.sv
// Command PIO / engine control / status PIO bundle for lpr_cmd_sequencer.
interface lpr_cmd_sequencer_if;
    logic [31:0] cmd_word;
    logic        eng_done;
    logic        eng_error;
    logic        eng_start;
    logic        eng_abort;
    logic        eng_srst;
    logic [23:0] eng_arg;
    logic [31:0] status_word;
    logic        busy;
    logic        irq;

    modport master (
        output cmd_word, eng_done, eng_error,
        input  eng_start, eng_abort, eng_srst, eng_arg, status_word, busy, irq
    );

    modport slave (
        input  cmd_word, eng_done, eng_error,
        output eng_start, eng_abort, eng_srst, eng_arg, status_word, busy, irq
    );
endinterface

// File: rtl/lpr_cmd_field_decode.sv
// Splits the registered command word into opcode/tag/arg and flags legal opcodes.
module lpr_cmd_field_decode
    import lpr_cmd_pkg::*;
(
    input  logic [31:0] cmd_q,
    output logic [3:0]  op,
    output logic [3:0]  tag,
    output logic [23:0] arg,
    output logic        op_legal
);
    assign op       = cmd_q[OP_MSB:OP_LSB];
    assign tag      = cmd_q[TAG_MSB:TAG_LSB];
    assign arg      = cmd_q[ARG_MSB:0];
    assign op_legal = (op <= OP_CLR);
endmodule

// File: rtl/lpr_cmd_sequencer.sv
// Tag-change command sequencer driving LPR engine control pulses and a status word.
// Optional watchdog on WAIT_DONE enabled by defining LPR_CMD_WATCHDOG_EN.
module lpr_cmd_sequencer
    import lpr_cmd_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000,
    parameter int          CNT_W          = 16
) (
    input logic               clk,
    input logic               reset_n,
    lpr_cmd_sequencer_if.slave bus
);
    logic [31:0]      cmd_q;
    logic             armed_q;
    logic [3:0]       op, tag, last_tag, job_tag;
    logic [23:0]      arg, arg_q;
    logic             op_legal, new_cmd, wd_hit;
    state_t           state, state_nx;

    logic [3:0]       st_op, st_tag, ret_op, ret_tag;
    logic [7:0]       st_err, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             irq_q, irq_d;
    logic             start_q, abort_q, srst_q;
    logic             start_d, abort_d, srst_d, take, load_arg, retire;

    lpr_cmd_field_decode u_decode (
        .cmd_q    (cmd_q),
        .op       (op),
        .tag      (tag),
        .arg      (arg),
        .op_legal (op_legal)
    );

    assign new_cmd = armed_q && (tag != last_tag);

`ifdef LPR_CMD_WATCHDOG_EN
    logic [31:0] wd_cnt;

    // Held at zero outside WAIT_DONE so every job starts a fresh window.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) wd_cnt <= '0;
        else          wd_cnt <= (state == ST_WAIT_DONE) ? wd_cnt + 32'd1 : '0;

    assign wd_hit = (state == ST_WAIT_DONE) && (wd_cnt == TIMEOUT_CYCLES - 32'd1);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign wd_hit         = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:      if (new_cmd && op == OP_START) state_nx = ST_DISPATCH;
            ST_DISPATCH:  state_nx = ST_WAIT_DONE;
            ST_WAIT_DONE: if (bus.eng_done || wd_hit ||
                              (new_cmd && (op == OP_ABORT || op == OP_SRST)))
                              state_nx = ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        start_d  = 1'b0;
        abort_d  = 1'b0;
        srst_d   = 1'b0;
        take     = 1'b0;
        load_arg = 1'b0;
        retire   = 1'b0;
        ret_op   = op;
        ret_tag  = tag;
        err_d    = st_err;
        cnt_d    = cnt_q;
        irq_d    = irq_q;
        case (state)
            ST_IDLE: if (new_cmd) begin
                take     = 1'b1;
                load_arg = 1'b1;
                if (!op_legal) begin
                    retire = 1'b1;
                    err_d  = ERR_ILLEGAL;
                    irq_d  = 1'b1;
                end else if (op == OP_START) begin
                    start_d = 1'b1;
                end else begin
                    retire = 1'b1;
                    irq_d  = 1'b1;
                    case (op)
                        OP_ABORT: abort_d = 1'b1;
                        OP_SRST:  srst_d  = 1'b1;
                        OP_CLR: begin
                            err_d = ERR_NONE;
                            irq_d = 1'b0;
                            cnt_d = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_WAIT_DONE: begin
                // Completion has priority; a coincident command stays pending
                // (tag not consumed) and is taken from IDLE next cycle.
                if (bus.eng_done) begin
                    retire  = 1'b1;
                    ret_op  = OP_START;
                    ret_tag = job_tag;
                    cnt_d   = cnt_q + CNT_W'(1);
                    irq_d   = 1'b1;
                    if (bus.eng_error) err_d = ERR_ENGINE;
                end else if (new_cmd) begin
                    take   = 1'b1;
                    retire = 1'b1;
                    irq_d  = 1'b1;
                    if (op == OP_ABORT) begin
                        abort_d = 1'b1;
                        err_d   = ERR_ABORTED;
                    end else if (op == OP_SRST) begin
                        srst_d = 1'b1;
                    end else begin
                        err_d = ERR_BUSY;
                    end
                end else if (wd_hit) begin
                    retire  = 1'b1;
                    ret_op  = OP_START;
                    ret_tag = job_tag;
                    abort_d = 1'b1;
                    err_d   = ERR_TIMEOUT;
                    irq_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // The first cycle out of reset adopts whatever tag is on the port, so a
    // command still held by the host is not replayed after a reset.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            cmd_q    <= '0;
            armed_q  <= 1'b0;
            last_tag <= '0;
            job_tag  <= '0;
            arg_q    <= '0;
            start_q  <= 1'b0;
            abort_q  <= 1'b0;
            srst_q   <= 1'b0;
            st_op    <= '0;
            st_tag   <= '0;
            st_err   <= ERR_NONE;
            cnt_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            cmd_q   <= bus.cmd_word;
            armed_q <= 1'b1;
            start_q <= start_d;
            abort_q <= abort_d;
            srst_q  <= srst_d;
            if (!armed_q)  last_tag <= bus.cmd_word[TAG_MSB:TAG_LSB];
            else if (take) last_tag <= tag;
            if (load_arg)  arg_q   <= arg;
            if (start_d)   job_tag <= tag;
            if (retire) begin
                st_op  <= ret_op;
                st_tag <= ret_tag;
            end
            st_err <= err_d;
            cnt_q  <= cnt_d;
            irq_q  <= irq_d;
        end

    assign bus.eng_start   = start_q;
    assign bus.eng_abort   = abort_q;
    assign bus.eng_srst    = srst_q;
    assign bus.eng_arg     = arg_q;
    assign bus.status_word = {st_op, st_tag, st_err, 16'(cnt_q)};
    assign bus.busy        = (state != ST_IDLE);
    assign bus.irq         = irq_q;
endmodule

// File: tb/tb_lpr_cmd_sequencer.sv
// Scoreboard bench for lpr_cmd_sequencer: a transaction-level model queues the
// expected observable events; a negedge monitor matches them as they appear.
module tb_lpr_cmd_sequencer;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [31:0] cyc;
        logic        st;
        logic        ab;
        logic        sr;
        logic [31:0] status;
        logic        irq;
        logic        busy;
        logic [23:0] arg;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];

    logic [3:0]  m_op, m_tag, m_jtag;
    logic [7:0]  m_err;
    int          m_cnt;
    bit          m_irq, m_job;
    logic [23:0] m_arg;
    int          m_last;

    lpr_cmd_sequencer_if ifc();

    lpr_cmd_sequencer #(.TIMEOUT_CYCLES(32'd16), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (transaction level) ----------------
    task automatic push(input int at, input bit s, input bit a, input bit r);
        ev_t e;
        e.cyc    = 32'(at);
        e.st     = s;
        e.ab     = a;
        e.sr     = r;
        e.status = {m_op, m_tag, m_err, 16'(m_cnt)};
        e.irq    = m_irq;
        e.busy   = m_job;
        e.arg    = m_arg;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_op = '0; m_tag = '0; m_jtag = '0; m_err = '0; m_cnt = 0;
        m_irq = 1'b0; m_job = 1'b0; m_arg = '0;
        m_last = int'(ifc.cmd_word[27:24]);
        exp_q.delete();
    endtask

    task automatic m_cmd(input int op, input int tag, input logic [23:0] arg, input int at);
        m_last = tag;
        if (!m_job) begin
            m_arg = arg;
            if (op == 1) begin
                m_job  = 1'b1;
                m_jtag = 4'(tag);
                push(at, 1'b1, 1'b0, 1'b0);
                return;
            end
            m_op = 4'(op); m_tag = 4'(tag); m_irq = 1'b1;
            if (op > 4) m_err = 8'h01;
            else if (op == 4) begin m_err = 8'h00; m_irq = 1'b0; m_cnt = 0; end
            push(at, 1'b0, op == 2, op == 3);
        end else begin
            m_op = 4'(op); m_tag = 4'(tag); m_irq = 1'b1;
            if (op == 2)      begin m_err = 8'h05; m_job = 1'b0; end
            else if (op == 3) m_job = 1'b0;
            else              m_err = 8'h02;
            push(at, 1'b0, op == 2, op == 3);
        end
    endtask

    task automatic m_done(input bit err, input int at);
        m_job = 1'b0;
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        if (err) m_err = 8'h04;
        m_irq = 1'b1; m_op = 4'd1; m_tag = m_jtag;
        push(at, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic m_timeout(input int at);
        m_job = 1'b0; m_err = 8'h03; m_irq = 1'b1; m_op = 4'd1; m_tag = m_jtag;
        push(at, 1'b0, 1'b1, 1'b0);
    endtask

    function automatic int newtag();
        int t;
        do t = int'($urandom_range(0, 15)); while (t == m_last);
        return t;
    endfunction

    function automatic int randop();
        int r;
        r = int'($urandom_range(0, 9));
        if (r <= 4) return 1;
        if (r == 5) return 0;
        if (r == 6) return 2;
        if (r == 7) return 3;
        if (r == 8) return 4;
        return int'($urandom_range(5, 15));
    endfunction

    // ---------------- drivers (called at posedge + 1) ----------------
    task automatic send(input int op, input int tag, input logic [23:0] arg);
        ifc.cmd_word = {4'(op), 4'(tag), arg};
        m_cmd(op, tag, arg, cyc + 2);
        tick(3);
    endtask

    task automatic done(input bit err, input bit modelled);
        ifc.eng_done  = 1'b1;
        ifc.eng_error = err;
        if (modelled) m_done(err, cyc + 1);
        tick(1);
        ifc.eng_done  = 1'b0;
        ifc.eng_error = 1'b0;
        tick(2);
    endtask

    // ---------------- monitor ----------------
    logic [31:0] prev_status = '0;
    logic        prev_irq = 1'b0;

    always @(negedge clk) begin
        ev_t a, e;
        if (!reset_n) begin
            prev_status = '0;
            prev_irq    = 1'b0;
        end else begin
            a.cyc    = 32'(cyc);
            a.st     = ifc.eng_start;
            a.ab     = ifc.eng_abort;
            a.sr     = ifc.eng_srst;
            a.status = ifc.status_word;
            a.irq    = ifc.irq;
            a.busy   = ifc.busy;
            a.arg    = ifc.eng_arg;
            if (a.st || a.ab || a.sr || a.status != prev_status || a.irq != prev_irq) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d start=%b abort=%b srst=%b status=%h irq=%b",
                             cyc, a.st, a.ab, a.sr, a.status, a.irq);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        errors++;
                        $display("FAIL event got{cyc=%0d s%b a%b r%b st=%h irq%b busy%b arg=%h} want{cyc=%0d s%b a%b r%b st=%h irq%b busy%b arg=%h}",
                                 a.cyc, a.st, a.ab, a.sr, a.status, a.irq, a.busy, a.arg,
                                 e.cyc, e.st, e.ab, e.sr, e.status, e.irq, e.busy, e.arg);
                    end
                end
                prev_status = a.status;
                prev_irq    = a.irq;
            end else if (exp_q.size() > 0 && int'(exp_q[0].cyc) < cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_event at cyc=%0d got nothing want s%b a%b r%b st=%h",
                         e.cyc, e.st, e.ab, e.sr, e.status);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int t;
        reset_n       = 1'b0;
        ifc.cmd_word  = '0;
        ifc.eng_done  = 1'b0;
        ifc.eng_error = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({ifc.eng_start, ifc.eng_abort, ifc.eng_srst, ifc.busy,
                                  ifc.irq, ifc.eng_arg, ifc.status_word}), 64'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        tick(3);

        // first START, then completion
        send(1, 1, 24'h0000AB);
        chk("t1_busy", 64'(ifc.busy), 64'd1);
        chk("t1_arg", 64'(ifc.eng_arg), 64'h0000AB);
        done(1'b0, 1'b1);
        chk("t1_status", 64'(ifc.status_word), 64'h1100_0001);
        chk("t1_irq", 64'(ifc.irq), 64'd1);

        // unchanged tag held: monitor flags any event
        tick(100);

        // command while busy is rejected, job completes normally
        send(1, 2, 24'h0);
        send(1, 3, 24'h0);
        chk("t3_reject_status", 64'(ifc.status_word), 64'h1302_0001);
        chk("t3_busy", 64'(ifc.busy), 64'd1);
        done(1'b0, 1'b1);
        chk("t3_done_status", 64'(ifc.status_word), 64'h1202_0002);

        // abort in flight
        send(1, 4, 24'h0);
        send(2, 5, 24'h0);
        chk("t4_status", 64'(ifc.status_word), 64'h2505_0002);
        chk("t4_busy", 64'(ifc.busy), 64'd0);

        // illegal opcode then clear
        send(15, 6, 24'h0);
        chk("t5_illegal_status", 64'(ifc.status_word), 64'hF601_0002);
        chk("t5_illegal_irq", 64'(ifc.irq), 64'd1);
        send(4, 7, 24'h0);
        chk("t5_clr_status", 64'(ifc.status_word), 64'h4700_0000);
        chk("t5_clr_irq", 64'(ifc.irq), 64'd0);

        // eng_done while idle is ignored
        done(1'b0, 1'b0);

        // eng_done during DISPATCH is ignored; real done carries an engine error
        ifc.cmd_word = {4'd1, 4'd8, 24'h000123};
        m_cmd(1, 8, 24'h000123, cyc + 2);
        tick(2);
        ifc.eng_done = 1'b1;
        tick(1);
        ifc.eng_done = 1'b0;
        tick(2);
        done(1'b1, 1'b1);
        chk("dispatch_done_status", 64'(ifc.status_word), 64'h1804_0001);

        // eng_done coinciding with a new ABORT: done counted, abort issued next cycle
        send(1, 9, 24'h0);
        ifc.cmd_word = {4'd2, 4'd10, 24'h00BEEF};
        tick(1);
        ifc.eng_done = 1'b1;
        m_done(1'b0, cyc + 1);
        m_cmd(2, 10, 24'h00BEEF, cyc + 2);
        tick(1);
        ifc.eng_done = 1'b0;
        tick(3);
        chk("coincide_status", 64'(ifc.status_word), 64'h2A04_0002);

        // counter wrap at 2^CNT_W
        send(4, newtag(), 24'h0);
        for (int i = 0; i < (1 << CNT_W); i++) begin
            send(1, newtag(), 24'($urandom));
            done(1'b0, 1'b1);
        end
        chk("cnt_wrap", 64'(ifc.status_word[15:0]), 64'd0);

        // randomized command/engine traffic
        for (int i = 0; i < 40; i++) begin
            int  op;
            int  k;
            bit  ended;
            op = randop();
            send(op, newtag(), 24'($urandom));
            if (op == 1) begin
                k     = int'($urandom_range(0, 2));
                ended = 1'b0;
                for (int j = 0; j < k && !ended; j++) begin
                    int mop;
                    mop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 3)) : int'($urandom_range(0, 15));
                    send(mop, newtag(), 24'($urandom));
                    if (mop == 2 || mop == 3) ended = 1'b1;
                end
                if (!ended) done(1'($urandom_range(0, 1)), 1'b1);
            end
        end

        // async reset in the middle of a job, command left on the port
        send(1, newtag(), 24'h5A5A5A);
        tick(2);
        #2 reset_n = 1'b0;
        chk("queue_empty_at_reset", 64'(exp_q.size()), 64'd0);
        model_reset();
        @(negedge clk);
        chk("midjob_reset_outputs", 64'({ifc.eng_start, ifc.eng_abort, ifc.eng_srst, ifc.busy,
                                         ifc.irq, ifc.eng_arg, ifc.status_word}), 64'd0);
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        tick(20);
        chk("post_reset_status", 64'(ifc.status_word), 64'd0);
        chk("post_reset_busy", 64'(ifc.busy), 64'd0);
        t = newtag();
        send(1, t, 24'h000042);
        done(1'b0, 1'b1);
        chk("post_reset_job", 64'(ifc.status_word), 64'({4'h1, 4'(t), 8'h00, 16'h0001}));

`ifdef LPR_CMD_WATCHDOG_EN
        // watchdog: no eng_done, abort 16 clk after entering WAIT_DONE
        t = newtag();
        ifc.cmd_word = {4'd1, 4'(t), 24'h0};
        m_cmd(1, t, 24'h0, cyc + 2);
        m_timeout(cyc + 19);
        tick(21);
        chk("wd_err", 64'(ifc.status_word[23:16]), 64'h03);
        chk("wd_busy", 64'(ifc.busy), 64'd0);
`endif

        tick(5);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
